spi_trace_master: RTL and testbench

SPI_TRACE_MASTER -- requirements
Module: spi_trace_master

---
 rtl/spi_trace_master_if.sv | 30 +++
 rtl/spi_trace_master.sv | 173 +++++++++++++++++
 tb/tb_spi_trace_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_trace_master_if.sv
// spi_trace_master_if: command, response and trace-capture signals of the SPI trace master
interface spi_trace_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_parity;
    logic [4:0]  cmd_bits;
    logic [1:0]  cmd_width;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_parity;
    logic        rsp_timeout;
    logic        trace_hdr_valid;
    logic        trace_hdr_active;
    logic [1:0]  trace_hdr_width;
    logic        trace_hdr_sync;
    logic        trace_valid;
    logic [15:0] trace_word;
    modport master (
        output cmd_valid, cmd_op, cmd_parity, cmd_bits, cmd_width, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_parity, rsp_timeout,
        input  trace_hdr_valid, trace_hdr_active, trace_hdr_width, trace_hdr_sync, trace_valid, trace_word
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_parity, cmd_bits, cmd_width, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_parity, rsp_timeout,
        output trace_hdr_valid, trace_hdr_active, trace_hdr_width, trace_hdr_sync, trace_valid, trace_word
    );
endinterface

// File: rtl/spi_trace_master.sv
// spi_trace_master: SPI master issuing SWD read/write and trace-frame transactions
module spi_trace_master #(
    parameter int CLK_DIV  = 4,
    parameter int POLL_MAX = 64,
    parameter int CS_GAP   = 8
) (
    input  logic clk,
    input  logic rst,
    spi_trace_master_if.slave bus,
    output logic busy_o,
    output logic spi_sel_o,
    output logic spi_sclk_o,
    output logic spi_mosi_o,
    input  logic spi_miso_i
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [3:0] IDLE = 4'd0, SEL = 4'd1, CMD = 4'd2, WDATA = 4'd3, POLL = 4'd4,
                           RDATA = 4'd5, THDR = 4'd6, TDATA = 4'd7, GAP = 4'd8;
    logic [3:0]  state_q, state_d, cnt_q, cnt_d;
    logic        rdy_q, rdy_d, sel_q, sel_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d, lo_q, lo_d;
    logic [6:0]  rx_q, rx_d;
    logic [1:0]  op_q, op_d, width_q, width_d, hdr_width_q, hdr_width_d;
    logic        par_q, par_d, rpar_q, rpar_d, tmo_q, tmo_d;
    logic [4:0]  bits_q, bits_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        rsp_valid_q, rsp_valid_d, hdr_valid_q, hdr_valid_d, tvalid_q, tvalid_d;
    logic        hdr_active_q, hdr_active_d, hdr_sync_q, hdr_sync_d;
    logic [15:0] tword_q, tword_d;
    logic        tick, fall, done, byte_st;
    logic [7:0]  rb, cmd_byte;
    logic [2:0]  n;
    assign tick = div_q == DW'(CLK_DIV - 1);
    assign fall = tick && sclk_q;
    assign done = fall && bit_q == 3'd7;
    assign rb = {rx_q, spi_miso_i};
    assign n = {1'b0, bits_q[4:3]} + 3'd1;
    assign byte_st = state_q inside {CMD, WDATA, POLL, RDATA, THDR, TDATA};
    assign cmd_byte = op_q == 2'd0 ? {6'b100000, width_q} :
                      op_q == 2'd1 ? {2'b00, par_q, bits_q} :
                      op_q == 2'd2 ? {2'b01, par_q, bits_q} : 8'hA5;
    always_comb begin
        state_d = state_q; sel_d = sel_q; sclk_d = sclk_q; mosi_d = mosi_q;
        div_d = div_q; bit_d = bit_q; sh_d = sh_q; rx_d = rx_q; lo_d = lo_q;
        cnt_d = cnt_q; pc_d = pc_q; gap_d = gap_q;
        op_d = op_q; par_d = par_q; bits_d = bits_q; width_d = width_q; wdata_d = wdata_q;
        rdata_d = rdata_q; rpar_d = rpar_q; tmo_d = tmo_q; tword_d = tword_q;
        hdr_active_d = hdr_active_q; hdr_width_d = hdr_width_q; hdr_sync_d = hdr_sync_q;
        rsp_valid_d = 1'b0; hdr_valid_d = 1'b0; tvalid_d = 1'b0;
        if (byte_st) begin
            div_d = tick ? '0 : div_q + DW'(1);
            sclk_d = tick ? !sclk_q : sclk_q;
            if (fall) begin
                rx_d = rb[6:0];
                bit_d = bit_q + 3'd1;
                sh_d = {sh_q[6:0], 1'b0};
                mosi_d = sh_q[6];
            end
            // each completed byte is followed by a filler unless a state overrides it
            if (done) begin
                sh_d = 8'hFF;
                mosi_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: if (bus.cmd_valid && rdy_q) begin
                state_d = SEL; op_d = bus.cmd_op; par_d = bus.cmd_parity; bits_d = bus.cmd_bits;
                width_d = bus.cmd_width; wdata_d = bus.cmd_wdata; rdata_d = '0; rpar_d = 1'b0; tmo_d = 1'b0;
            end
            SEL: begin
                state_d = CMD; sel_d = 1'b0; sclk_d = 1'b0; div_d = '0; bit_d = '0;
                sh_d = cmd_byte; mosi_d = cmd_byte[7];
            end
            CMD: if (done) begin
                state_d = op_q == 2'd0 ? THDR : op_q == 2'd1 ? WDATA : op_q == 2'd2 ? POLL : GAP;
                if (op_q == 2'd1) begin
                    sh_d = wdata_q[7:0];
                    mosi_d = wdata_q[7];
                end
            end
            WDATA: if (done) begin
                cnt_d = cnt_q + 4'd1;
                wdata_d = {8'h00, wdata_q[31:8]};
                if (cnt_q[2:0] + 3'd1 == n) state_d = POLL;
                else begin
                    sh_d = wdata_q[15:8];
                    mosi_d = wdata_q[15];
                end
            end
            POLL: if (done) begin
                pc_d = pc_q + PW'(1);
                if (op_q == 2'd1 && rb == 8'h90) begin
                    state_d = GAP; rsp_valid_d = 1'b1;
                end else if (op_q == 2'd2 && rb[7:3] == 5'b10001) begin
                    state_d = RDATA; rpar_d = rb[2];
                end else if (pc_q == PW'(POLL_MAX - 1)) begin
                    state_d = GAP; rsp_valid_d = 1'b1; tmo_d = 1'b1; rdata_d = '0;
                end
            end
            RDATA: if (done) begin
                rdata_d[{cnt_q[1:0], 3'b000} +: 8] = rb;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[2:0] + 3'd1 == n) begin
                    state_d = GAP; rsp_valid_d = 1'b1;
                end
            end
            THDR: if (done) begin
                state_d = TDATA; hdr_valid_d = 1'b1;
                hdr_active_d = rb[7]; hdr_width_d = rb[2:1]; hdr_sync_d = rb[0];
            end
            TDATA: if (done) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q[0]) begin
                    tword_d = {rb, lo_q};
                    tvalid_d = hdr_active_q;
                end else lo_d = rb;
                if (cnt_q == 4'd15) state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(CS_GAP - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0; pc_d = '0; gap_d = '0;
        end
        if (state_d == GAP && state_q != GAP) begin
            sel_d = 1'b1; mosi_d = 1'b0;
        end
        rdy_d = state_d == IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE; rdy_q <= 1'b0; sel_q <= 1'b1; sclk_q <= 1'b0; mosi_q <= 1'b0;
            div_q <= '0; bit_q <= '0; sh_q <= '0; rx_q <= '0; lo_q <= '0;
            cnt_q <= '0; pc_q <= '0; gap_q <= '0;
            op_q <= '0; par_q <= 1'b0; bits_q <= '0; width_q <= '0; wdata_q <= '0;
            rdata_q <= '0; rpar_q <= 1'b0; tmo_q <= 1'b0; tword_q <= '0;
            hdr_active_q <= 1'b0; hdr_width_q <= '0; hdr_sync_q <= 1'b0;
            rsp_valid_q <= 1'b0; hdr_valid_q <= 1'b0; tvalid_q <= 1'b0;
        end else begin
            state_q <= state_d; rdy_q <= rdy_d; sel_q <= sel_d; sclk_q <= sclk_d; mosi_q <= mosi_d;
            div_q <= div_d; bit_q <= bit_d; sh_q <= sh_d; rx_q <= rx_d; lo_q <= lo_d;
            cnt_q <= cnt_d; pc_q <= pc_d; gap_q <= gap_d;
            op_q <= op_d; par_q <= par_d; bits_q <= bits_d; width_q <= width_d; wdata_q <= wdata_d;
            rdata_q <= rdata_d; rpar_q <= rpar_d; tmo_q <= tmo_d; tword_q <= tword_d;
            hdr_active_q <= hdr_active_d; hdr_width_q <= hdr_width_d; hdr_sync_q <= hdr_sync_d;
            rsp_valid_q <= rsp_valid_d; hdr_valid_q <= hdr_valid_d; tvalid_q <= tvalid_d;
        end
    end
    assign bus.cmd_ready = rdy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_parity = rpar_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.trace_hdr_valid = hdr_valid_q;
    assign bus.trace_hdr_active = hdr_active_q;
    assign bus.trace_hdr_width = hdr_width_q;
    assign bus.trace_hdr_sync = hdr_sync_q;
    assign bus.trace_valid = tvalid_q;
    assign bus.trace_word = tword_q;
    assign busy_o = state_q != IDLE;
    assign spi_sel_o = sel_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
endmodule

// File: tb/tb_spi_trace_master.sv
// tb_spi_trace_master: directed checks of spi_trace_master against a byte-level SPI slave model
`timescale 1ns/1ps
module tb_spi_trace_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, spi_sel, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;
    always #5 clk = ~clk;
    spi_trace_master_if bus();
    spi_trace_master #(.CLK_DIV(4), .POLL_MAX(4), .CS_GAP(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy),
        .spi_sel_o(spi_sel), .spi_sclk_o(spi_sclk), .spi_mosi_o(spi_mosi), .spi_miso_i(spi_miso)
    );
    int checks = 0;
    int errors = 0;
    logic [7:0] miso_fifo[$];
    logic [7:0] mosi_log[$];
    logic [7:0] miso_idle;
    logic [7:0] cur, rxs;
    int bitn = 0;
    int n_rsp = 0, n_hdr = 0;
    logic [31:0] c_rdata;
    logic c_par, c_tmo;
    logic [15:0] words[$];
    longint t_sel_fall, t_rise, t_sel_rise, t_busy_fall, t_rsp;
    logic armed = 1'b0;
    logic [7:0] exp_wr[5] = '{8'h3F, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [15:0] tw[8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
    int b_rsp, b_hdr, lb, wb;

    // slave drives MISO on the rising edge so it is stable when the master samples on the fall
    always @(posedge spi_sclk or posedge spi_sel) begin
        if (spi_sel) bitn = 0;
        else begin
            if (bitn == 0) begin
                if (miso_fifo.size() > 0) cur = miso_fifo.pop_front();
                else cur = miso_idle;
            end
            spi_miso = cur[7 - bitn];
            rxs = {rxs[6:0], spi_mosi};
            bitn++;
            if (bitn == 8) begin
                mosi_log.push_back(rxs);
                bitn = 0;
            end
        end
    end
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            n_rsp++;
            c_rdata = bus.rsp_rdata;
            c_par = bus.rsp_parity;
            c_tmo = bus.rsp_timeout;
        end
        if (bus.trace_hdr_valid) n_hdr++;
        if (bus.trace_valid) words.push_back(bus.trace_word);
    end
    always @(negedge spi_sel or posedge spi_sclk) begin
        if (spi_sclk) begin
            if (armed) begin
                t_rise = $time;
                armed = 1'b0;
            end
        end else begin
            t_sel_fall = $time;
            armed = 1'b1;
        end
    end
    always @(posedge spi_sel) t_sel_rise = $time;
    always @(negedge busy) t_busy_fall = $time;
    always @(posedge bus.rsp_valid) t_rsp = $time;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic par, input logic [4:0] bits,
                         input logic [1:0] width, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_parity = par;
        bus.cmd_bits = bits; bus.cmd_width = width; bus.cmd_wdata = wdata;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_op = ~op; bus.cmd_parity = ~par;
        bus.cmd_bits = ~bits; bus.cmd_width = ~width; bus.cmd_wdata = ~wdata;
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_bound", busy, 0);
    endtask

    task automatic mark();
        b_rsp = n_rsp; b_hdr = n_hdr; lb = mosi_log.size(); wb = words.size();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_parity = 1'b0;
        bus.cmd_bits = '0; bus.cmd_width = '0; bus.cmd_wdata = '0;
        miso_idle = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sel", spi_sel, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_flags", {bus.rsp_valid, bus.rsp_parity, bus.rsp_timeout, bus.trace_valid,
                          bus.trace_hdr_valid, bus.trace_hdr_active, bus.trace_hdr_sync, bus.trace_hdr_width}, 0);
        chk("rst_tword", bus.trace_word, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);

        // SWD write, 4 data bytes, completion on third poll byte
        mark();
        repeat (5) miso_fifo.push_back(8'h00);
        miso_fifo.push_back(8'h10); miso_fifo.push_back(8'h10); miso_fifo.push_back(8'h90);
        issue(2'd1, 1'b1, 5'd31, 2'd0, 32'h12345678);
        wait_done();
        chk("wr_nbytes", mosi_log.size() - lb, 8);
        for (int i = 0; i < 5; i++) chk("wr_mosi", mosi_log[lb + i], exp_wr[i]);
        for (int i = 5; i < 8; i++) chk("wr_filler", mosi_log[lb + i], 8'hFF);
        chk("wr_sel_to_sclk", 32'(t_rise - t_sel_fall), 40);
        chk("wr_rsp_count", n_rsp - b_rsp, 1);
        chk("wr_timeout", c_tmo, 0);
        chk("wr_rsp_time", 32'(t_rsp), 32'(t_sel_rise));
        chk("wr_gap", 32'(t_busy_fall - t_sel_rise), 80);

        // SWD read, header after two busy bytes
        mark();
        miso_fifo.push_back(8'h00); miso_fifo.push_back(8'h08); miso_fifo.push_back(8'h08);
        miso_fifo.push_back(8'h8C); miso_fifo.push_back(8'hAB);
        issue(2'd2, 1'b0, 5'd7, 2'd0, 32'h0);
        wait_done();
        chk("rd_nbytes", mosi_log.size() - lb, 5);
        chk("rd_cmd", mosi_log[lb], 8'h47);
        for (int i = 1; i < 5; i++) chk("rd_filler", mosi_log[lb + i], 8'hFF);
        chk("rd_rsp_count", n_rsp - b_rsp, 1);
        chk("rd_parity", c_par, 1);
        chk("rd_rdata", c_rdata, 32'h000000AB);
        chk("rd_timeout", c_tmo, 0);

        // read with slave stuck busy -> timeout after POLL_MAX poll bytes
        mark();
        miso_idle = 8'h08;
        miso_fifo.push_back(8'h00);
        issue(2'd2, 1'b0, 5'd7, 2'd0, 32'h0);
        wait_done();
        miso_idle = 8'h00;
        chk("to_nbytes", mosi_log.size() - lb, 5);
        chk("to_rsp_count", n_rsp - b_rsp, 1);
        chk("to_timeout", c_tmo, 1);
        chk("to_rdata", c_rdata, 0);
        chk("to_gap", 32'(t_busy_fall - t_sel_rise), 80);

        // trace frame with active header
        mark();
        miso_fifo.push_back(8'h00); miso_fifo.push_back(8'h87);
        for (int i = 0; i < 8; i++) begin
            miso_fifo.push_back(tw[i][7:0]);
            miso_fifo.push_back(tw[i][15:8]);
        end
        issue(2'd0, 1'b0, 5'd0, 2'd3, 32'h0);
        wait_done();
        chk("tr_cmd", mosi_log[lb], 8'h83);
        chk("tr_nbytes", mosi_log.size() - lb, 18);
        chk("tr_hdr_count", n_hdr - b_hdr, 1);
        chk("tr_hdr_active", bus.trace_hdr_active, 1);
        chk("tr_hdr_width", bus.trace_hdr_width, 3);
        chk("tr_hdr_sync", bus.trace_hdr_sync, 1);
        chk("tr_words", words.size() - wb, 8);
        if (words.size() - wb == 8) begin
            chk("tr_word0", words[wb], 16'h1234);
            chk("tr_word3", words[wb + 3], 16'hDEF0);
            chk("tr_word7", words[wb + 7], 16'hBDF1);
        end
        chk("tr_no_rsp", n_rsp - b_rsp, 0);

        // trace frame with inactive header: filler still clocked, no words
        mark();
        miso_fifo.push_back(8'h00); miso_fifo.push_back(8'h06);
        issue(2'd0, 1'b0, 5'd0, 2'd1, 32'h0);
        wait_done();
        chk("tri_cmd", mosi_log[lb], 8'h81);
        chk("tri_nbytes", mosi_log.size() - lb, 18);
        chk("tri_hdr_count", n_hdr - b_hdr, 1);
        chk("tri_hdr_fields", {bus.trace_hdr_active, bus.trace_hdr_width, bus.trace_hdr_sync}, 4'b0110);
        chk("tri_words", words.size() - wb, 0);

        // frame reset while a second command is held valid during busy
        mark();
        issue(2'd3, 1'b0, 5'd0, 2'd0, 32'h0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_bits = 5'd31;
        repeat (30) @(negedge clk);
        chk("fr_busy_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        wait_done();
        chk("fr_nbytes", mosi_log.size() - lb, 1);
        chk("fr_cmd", mosi_log[lb], 8'hA5);
        chk("fr_no_rsp", n_rsp - b_rsp, 0);

        // asynchronous reset during the third bit of the first write-data byte
        mark();
        issue(2'd1, 1'b1, 5'd31, 2'd0, 32'hCAFEF00D);
        begin
            int n = 0;
            while (!(mosi_log.size() == lb + 1 && bitn == 3) && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rs_reached_wdata", bitn, 3);
        #1 rst = 1'b1;
        #1;
        chk("rs_sel_async", spi_sel, 1);
        chk("rs_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ready", bus.cmd_ready, 1);
        chk("rs_no_rsp", n_rsp - b_rsp, 0);
        chk("rs_no_trace", words.size() - wb, 0);
        mark();
        miso_fifo.delete();
        miso_fifo.push_back(8'h00); miso_fifo.push_back(8'h08); miso_fifo.push_back(8'h08);
        miso_fifo.push_back(8'h8C); miso_fifo.push_back(8'hAB);
        issue(2'd2, 1'b0, 5'd7, 2'd0, 32'h0);
        wait_done();
        chk("rs_rd_cmd", mosi_log[lb], 8'h47);
        chk("rs_rd_count", n_rsp - b_rsp, 1);
        chk("rs_rd_rdata", c_rdata, 32'h000000AB);
        chk("rs_rd_parity", c_par, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
